// File: rtl/msk_aes128_round_seq_if.sv
// Control bundle between the masked AES round sequencer and the state/key
// register block: request/response handshake plus per-cycle datapath strobes.
interface msk_aes128_round_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       init;
    logic       state_en;
    logic       key_en;
    logic [7:0] rcon;
    logic       last_round;
    logic [3:0] round_idx;
    logic       cleaning_on;
    logic       rnd_req;
    logic       busy;

    modport master (
        output in_valid, out_ready,
        input  in_ready, out_valid, init, state_en, key_en, rcon,
               last_round, round_idx, cleaning_on, rnd_req, busy
    );

    modport slave (
        input  in_valid, out_ready,
        output in_ready, out_valid, init, state_en, key_en, rcon,
               last_round, round_idx, cleaning_on, rnd_req, busy
    );
endinterface

// File: rtl/msk_aes128_round_seq.sv
// Sequencer for the masked AES-128 round-with-cleaning datapath: ten pipelined
// rounds, result handshake, optional zero-share flush (MSKAES_SEQ_CLEANING_EN).
module msk_aes128_round_seq #(
    parameter int LATENCY = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    msk_aes128_round_seq_if.slave        bus
);

`ifdef MSKAES_SEQ_CLEANING_EN
    typedef enum logic [1:0] {IDLE, ROUND, DONE, CLEAN} state_e;
    localparam state_e RST_STATE = CLEAN;
`else
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;
    localparam state_e RST_STATE = IDLE;
`endif

    localparam logic [3:0] LAT_LAST   = 4'(LATENCY - 1);
    localparam logic [3:0] LAST_ROUND = 4'd10;

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] lat_q,   lat_d;
    logic [7:0] rcon_q,  rcon_d;

    logic       in_ready, out_valid, init, state_en, key_en;
    logic       last_round, cleaning_on, rnd_req, busy;
    logic [7:0] rcon;
    logic [3:0] round_idx;

    // GF(2^8) doubling with the AES reduction polynomial
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            round_q <= '0;
            lat_q   <= '0;
            rcon_q  <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            lat_q   <= lat_d;
            rcon_q  <= rcon_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        lat_d       = lat_q;
        rcon_d      = rcon_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        init        = 1'b0;
        state_en    = 1'b0;
        key_en      = 1'b0;
        last_round  = 1'b0;
        cleaning_on = 1'b0;
        rnd_req     = 1'b0;
        busy        = 1'b1;
        rcon        = 8'h00;
        round_idx   = 4'd0;

        unique case (state_q)
            IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    init     = 1'b1;
                    state_en = 1'b1;
                    key_en   = 1'b1;
                    state_d  = ROUND;
                    round_d  = 4'd1;
                    lat_d    = 4'd0;
                    rcon_d   = 8'h01;
                end
            end

            ROUND: begin
                rnd_req    = 1'b1;
                rcon       = rcon_q;
                round_idx  = round_q;
                last_round = (round_q == LAST_ROUND);
                lat_d      = lat_q + 4'd1;
                // Round unit output lands on the last pipeline cycle
                if (lat_q == LAT_LAST) begin
                    state_en = 1'b1;
                    key_en   = 1'b1;
                    lat_d    = 4'd0;
                    if (round_q != LAST_ROUND) begin
                        round_d = round_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                    end else begin
                        round_d = 4'd0;
                        rcon_d  = 8'h00;
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    lat_d = 4'd0;
`ifdef MSKAES_SEQ_CLEANING_EN
                    state_d = CLEAN;
`else
                    state_d = IDLE;
`endif
                end
            end

`ifdef MSKAES_SEQ_CLEANING_EN
            // Push zero shares through every pipeline stage before the next block
            CLEAN: begin
                cleaning_on = 1'b1;
                rnd_req     = 1'b1;
                lat_d       = lat_q + 4'd1;
                if (lat_q == LAT_LAST) begin
                    lat_d   = 4'd0;
                    state_d = IDLE;
                end
            end
`endif

            default: state_d = RST_STATE;
        endcase
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.init        = init;
    assign bus.state_en    = state_en;
    assign bus.key_en      = key_en;
    assign bus.rcon        = rcon;
    assign bus.last_round  = last_round;
    assign bus.round_idx   = round_idx;
    assign bus.cleaning_on = cleaning_on;
    assign bus.rnd_req     = rnd_req;
    assign bus.busy        = busy;

endmodule

// File: tb/tb_msk_aes128_round_seq.sv
// Directed bench for msk_aes128_round_seq: LATENCY=4 and LATENCY=1 instances,
// expectations follow the MSKAES_SEQ_CLEANING_EN setting of the build.
module tb_msk_aes128_round_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total  = 0;
    logic sel = 1'b0;

`ifdef MSKAES_SEQ_CLEANING_EN
    localparam bit CLN = 1'b1;
`else
    localparam bit CLN = 1'b0;
`endif

    msk_aes128_round_seq_if if4 ();
    msk_aes128_round_seq_if if1 ();

    msk_aes128_round_seq #(.LATENCY(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    msk_aes128_round_seq #(.LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    always #5 clk = ~clk;

    logic       o_in_ready, o_out_valid, o_init, o_state_en, o_key_en;
    logic       o_last_round, o_cleaning_on, o_rnd_req, o_busy;
    logic [7:0] o_rcon;
    logic [3:0] o_round_idx;
    logic [7:0] rc_tab [10];

    always_comb begin
        o_in_ready    = sel ? if1.in_ready    : if4.in_ready;
        o_out_valid   = sel ? if1.out_valid   : if4.out_valid;
        o_init        = sel ? if1.init        : if4.init;
        o_state_en    = sel ? if1.state_en    : if4.state_en;
        o_key_en      = sel ? if1.key_en      : if4.key_en;
        o_last_round  = sel ? if1.last_round  : if4.last_round;
        o_cleaning_on = sel ? if1.cleaning_on : if4.cleaning_on;
        o_rnd_req     = sel ? if1.rnd_req     : if4.rnd_req;
        o_busy        = sel ? if1.busy        : if4.busy;
        o_rcon        = sel ? if1.rcon        : if4.rcon;
        o_round_idx   = sel ? if1.round_idx   : if4.round_idx;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic set_iv(input logic v);
        if (sel) if1.in_valid = v;
        else     if4.in_valid = v;
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready",    o_in_ready,    !CLN);
        chk("rst_cleaning_on", o_cleaning_on, CLN);
        chk("rst_busy",        o_busy,        CLN);
        chk("rst_out_valid",   o_out_valid,   0);
        chk("rst_state_en",    o_state_en,    0);
        chk("rst_last_round",  o_last_round,  0);
        chk("rst_rcon",        o_rcon,        0);
        chk("rst_round_idx",   o_round_idx,   0);
    endtask

    // Release reset at a falling edge, then wait out the post-reset flush (L=4)
    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        if (CLN) begin
            for (int i = 0; i < 4; i++) begin
                chk("post_rst_cleaning", o_cleaning_on, 1);
                chk("post_rst_in_ready", o_in_ready, 0);
                @(negedge clk);
                #1;
            end
        end
        chk("post_rst_idle", o_in_ready, 1);
    endtask

    // Called at a falling edge with the selected DUT in IDLE
    task automatic enc(input logic s, input int L, input int hold, input bit ivh);
        int r;
        sel = s;
        set_iv(1'b1);
        #1;
        chk("acc_in_ready", o_in_ready, 1);
        chk("acc_init",     o_init,     1);
        chk("acc_state_en", o_state_en, 1);
        chk("acc_key_en",   o_key_en,   1);
        for (int c = 1; c <= 10 * L; c++) begin
            @(negedge clk);
            if (!ivh) set_iv(1'b0);
            if4.out_ready = 1'b1;
            if1.out_ready = 1'b1;
            #1;
            r = (c - 1) / L + 1;
            chk("rnd_state_en",   o_state_en,   (c % L) == 0);
            chk("rnd_key_en",     o_key_en,     (c % L) == 0);
            chk("rnd_rcon",       o_rcon,       rc_tab[r-1]);
            chk("rnd_round_idx",  o_round_idx,  r);
            chk("rnd_last_round", o_last_round, r == 10);
            chk("rnd_rnd_req",    o_rnd_req,    1);
            chk("rnd_init",       o_init,       0);
            chk("rnd_in_ready",   o_in_ready,   0);
            chk("rnd_out_valid",  o_out_valid,  0);
        end
        for (int d = 0; d <= hold; d++) begin
            @(negedge clk);
            if4.out_ready = (d == hold);
            if1.out_ready = (d == hold);
            #1;
            chk("done_out_valid", o_out_valid, 1);
            chk("done_state_en",  o_state_en,  0);
            chk("done_rnd_req",   o_rnd_req,   0);
            chk("done_rcon",      o_rcon,      0);
            chk("done_busy",      o_busy,      1);
        end
        if (CLN) begin
            for (int c = 0; c < L; c++) begin
                @(negedge clk);
                #1;
                chk("cln_cleaning_on", o_cleaning_on, 1);
                chk("cln_rnd_req",     o_rnd_req,     1);
                chk("cln_in_ready",    o_in_ready,    0);
                chk("cln_init",        o_init,        0);
                chk("cln_out_valid",   o_out_valid,   0);
            end
        end
        @(negedge clk);
        #1;
        chk("end_in_ready", o_in_ready, 1);
        chk("end_init",     o_init,     ivh);
        chk("end_cleaning", o_cleaning_on, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        if4.in_valid = 1'b0; if4.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.out_ready = 1'b1;

        #2;
        chk_reset_vals();
        release_rst();

        enc(1'b0, 4, 0, 1'b0);
        enc(1'b0, 4, 7, 1'b0);
        enc(1'b0, 4, 0, 1'b1);
        enc(1'b0, 4, 0, 1'b1);

        // Third held request is now accepted; abort it 20 cycles in
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if4.in_valid = 1'b0;
        end
        #1;
        chk("mid_busy_pre", o_busy, 1);
        chk("mid_round_pre", o_round_idx, 5);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        release_rst();
        enc(1'b0, 4, 0, 1'b0);

        @(negedge clk);
        enc(1'b1, 1, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
